// File: rtl/mpu_ctrl_fsm.sv
`timescale 1ns/1ps
// ============================================================================
// mpu_ctrl_fsm
// ----------------------------------------------------------------------------
// Instruction sequencer for the matrix processing unit. One instruction is
// accepted per valid/ready handshake. The FSM then drives the bank read/write
// mux selects, the function-unit output mux and the per-bank write, byte-write
// and clear strobes until the instruction completes.
//
// Parameters
//   NUM_BANKS : number of BRAM banks (power of two, >= 2)
//   DATA_W    : bank word width in bits
//   BYTE_W    : host stream beat width in bits (DATA_W % BYTE_W == 0)
//   ALU_LAT   : extra cycles the function units need (0..15)
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   instr_valid/ready: instruction handshake (ready == !busy)
//   instr_op         : 4-bit opcode
//   instr_src        : source bank (A operand / unload bank)
//   instr_dst        : destination bank (D operand)
//   src_sel, dst_sel : registered read / write mux selects
//   out_sel          : function-unit mux (0 add, 1 shift, 2 sub, 3 mult)
//   bram_in_sel      : 1 selects the bank-to-bank copy path
//   bank_wr_en       : per-bank full-word write strobes
//   bank_byte_wr_en  : per-bank single-beat write strobes
//   bank_clr         : per-bank clear strobes
//   offset           : bit offset of the current stream beat
//   load_valid/ready : host-to-bank byte stream handshake
//   unload_valid/rdy : bank-to-host byte stream handshake
//   busy             : instruction in progress
//   done             : one-cycle completion pulse
//   err_illegal      : one-cycle illegal-opcode pulse
//
// Opcode map
//   00xx NOP, 0100 LOAD, 0101 COPY, 0110 UNLOAD, 0111 CLEAR,
//   10xx illegal, 1100 ADD, 1101 SHIFT, 1110 SUB, 1111 MULT
// ============================================================================
module mpu_ctrl_fsm #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 512,
    parameter int BYTE_W    = 8,
    parameter int ALU_LAT   = 0,
    parameter int SEL_W     = $clog2(NUM_BANKS),
    parameter int OFF_W     = $clog2(DATA_W)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [SEL_W-1:0]     instr_src,
    input  logic [SEL_W-1:0]     instr_dst,

    output logic [SEL_W-1:0]     src_sel,
    output logic [SEL_W-1:0]     dst_sel,
    output logic [1:0]           out_sel,
    output logic                 bram_in_sel,
    output logic [NUM_BANKS-1:0] bank_wr_en,
    output logic [NUM_BANKS-1:0] bank_byte_wr_en,
    output logic [NUM_BANKS-1:0] bank_clr,
    output logic [OFF_W-1:0]     offset,

    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 unload_valid,
    input  logic                 unload_ready,

    output logic                 busy,
    output logic                 done,
    output logic                 err_illegal
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BEATS = DATA_W / BYTE_W;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BEATS - 1);
    localparam logic [OFF_W-1:0] BYTE_STEP = OFF_W'(BYTE_W);

    // Function units with zero latency go straight to WRITE.
    localparam bit HAS_LAT = (ALU_LAT > 0);

    // The EXEC down-counter is loaded with ALU_LAT-1 so that EXEC lasts
    // exactly ALU_LAT cycles (it leaves when the counter reads zero).
    localparam logic [3:0] LAT_INIT = HAS_LAT ? 4'(ALU_LAT - 1) : 4'd0;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_RST_CLR = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_LOAD    = 3'd4;
    localparam logic [2:0] ST_UNLOAD  = 3'd5;
    localparam logic [2:0] ST_CLEAR   = 3'd6;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [SEL_W-1:0] src_sel_q;
    logic [SEL_W-1:0] dst_sel_q;
    logic [1:0]       out_sel_q;
    logic             is_copy_q;
    logic [3:0]       lat_cnt_q;
    logic [OFF_W-1:0] beat_q;
    logic [OFF_W-1:0] offset_q;
    logic             done_q;
    logic             err_q;

    // ------------------------------------------------------------------------
    // Opcode decode and handshake qualifiers
    // ------------------------------------------------------------------------
    logic op_nop;
    logic op_mem;
    logic op_illegal;
    logic op_alu;
    logic accept;
    logic load_xfer;
    logic unload_xfer;
    logic last_beat;
    logic step_beat;
    logic finishing;

    assign op_nop     = (instr_op[3:2] == 2'b00);
    assign op_mem     = (instr_op[3:2] == 2'b01);
    assign op_illegal = (instr_op[3:2] == 2'b10);
    assign op_alu     = (instr_op[3:2] == 2'b11);

    // Reset is folded in so an instruction offered during reset is never
    // taken, even though the registers would be overwritten anyway.
    assign accept = instr_valid && (state_q == ST_IDLE) && !reset;

    assign load_xfer   = (state_q == ST_LOAD)   && load_valid;
    assign unload_xfer = (state_q == ST_UNLOAD) && unload_ready;
    assign step_beat   = load_xfer || unload_xfer;
    assign last_beat   = (beat_q == LAST_BEAT);

    // Any instruction that completes in this cycle produces a done pulse in
    // the following (IDLE) cycle.
    assign finishing = (state_q == ST_WRITE) ||
                       (state_q == ST_CLEAR) ||
                       (step_beat && last_beat);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST_CLR: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (op_alu) begin
                        state_d = HAS_LAT ? ST_EXEC : ST_WRITE;
                    end else if (op_mem) begin
                        case (instr_op[1:0])
                            2'b00:   state_d = ST_LOAD;
                            2'b01:   state_d = ST_WRITE;
                            2'b10:   state_d = ST_UNLOAD;
                            default: state_d = ST_CLEAR;
                        endcase
                    end else begin
                        // NOP and illegal opcodes never leave IDLE.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE, ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_valid && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNLOAD: begin
                if (unload_ready && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RST_CLR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST_CLR;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Operand selects, latched at accept. out_sel only follows ALU ops so the
    // function-unit mux keeps its last setting across memory instructions.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            src_sel_q <= '0;
            dst_sel_q <= '0;
            out_sel_q <= 2'b00;
            is_copy_q <= 1'b0;
        end else if (accept) begin
            src_sel_q <= instr_src;
            dst_sel_q <= instr_dst;
            is_copy_q <= (instr_op == 4'b0101);
            if (op_alu) begin
                out_sel_q <= instr_op[1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Function-unit latency counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt_q <= 4'd0;
        end else if (accept && op_alu) begin
            lat_cnt_q <= LAT_INIT;
        end else if ((state_q == ST_EXEC) && (lat_cnt_q != 4'd0)) begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Stream beat counter and bit offset. Offset is kept as its own register
    // stepping by BYTE_W so no multiplier sits on the offset path. Both are
    // cleared whenever the FSM is about to be in IDLE, which also makes the
    // counter stop at the last beat instead of wrapping.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q   <= '0;
            offset_q <= '0;
        end else if (state_d == ST_IDLE) begin
            beat_q   <= '0;
            offset_q <= '0;
        end else if (step_beat) begin
            beat_q   <= beat_q + OFF_W'(1);
            offset_q <= offset_q + BYTE_STEP;
        end
    end

    // ------------------------------------------------------------------------
    // Completion and illegal-opcode pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= finishing;
            err_q  <= accept && op_illegal;
        end
    end

    // ------------------------------------------------------------------------
    // Strobes and stream handshakes. Everything is gated by reset directly so
    // an aborted instruction stops strobing in the very cycle reset rises,
    // and every bank is cleared while reset is high and in RST_CLR.
    // ------------------------------------------------------------------------
    logic [NUM_BANKS-1:0] dst_onehot;

    assign dst_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << dst_sel_q;

    always_comb begin
        bank_wr_en      = '0;
        bank_byte_wr_en = '0;
        bank_clr        = '0;
        bram_in_sel     = 1'b0;
        load_ready      = 1'b0;
        unload_valid    = 1'b0;
        if (reset || (state_q == ST_RST_CLR)) begin
            bank_clr = '1;
        end else begin
            case (state_q)
                ST_WRITE: begin
                    bank_wr_en  = dst_onehot;
                    bram_in_sel = is_copy_q;
                end
                ST_CLEAR: begin
                    bank_clr = dst_onehot;
                end
                ST_LOAD: begin
                    load_ready = 1'b1;
                    if (load_valid) begin
                        bank_byte_wr_en = dst_onehot;
                    end
                end
                ST_UNLOAD: begin
                    unload_valid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign busy        = reset || (state_q != ST_IDLE);
    assign instr_ready = !busy;
    assign src_sel     = src_sel_q;
    assign dst_sel     = dst_sel_q;
    assign out_sel     = out_sel_q;
    assign offset      = offset_q;
    assign done        = done_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_mpu_ctrl_fsm.sv
`timescale 1ns/1ps
// ============================================================================
// tb_mpu_ctrl_fsm
// ----------------------------------------------------------------------------
// Drives instruction streams (directed scenarios followed by random opcodes,
// operands, gaps and stream handshakes) into mpu_ctrl_fsm and compares every
// output every cycle against expectations derived from the instruction
// semantics: how many cycles each instruction occupies, which strobe it
// raises, which beat a stream is on, and when done/err_illegal pulse.
// ============================================================================
module tb_mpu_ctrl_fsm;

    localparam int NUM_BANKS = 4;
    localparam int DATA_W    = 512;
    localparam int BYTE_W    = 8;
    localparam int ALU_LAT   = 3;
    localparam int SEL_W     = 2;
    localparam int OFF_W     = 9;
    localparam int BEATS     = DATA_W / BYTE_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [3:0]           instr_op;
    logic [SEL_W-1:0]     instr_src;
    logic [SEL_W-1:0]     instr_dst;
    logic [SEL_W-1:0]     src_sel;
    logic [SEL_W-1:0]     dst_sel;
    logic [1:0]           out_sel;
    logic                 bram_in_sel;
    logic [NUM_BANKS-1:0] bank_wr_en;
    logic [NUM_BANKS-1:0] bank_byte_wr_en;
    logic [NUM_BANKS-1:0] bank_clr;
    logic [OFF_W-1:0]     offset;
    logic                 load_valid;
    logic                 load_ready;
    logic                 unload_valid;
    logic                 unload_ready;
    logic                 busy;
    logic                 done;
    logic                 err_illegal;

    always #5 clk = ~clk;

    mpu_ctrl_fsm #(
        .NUM_BANKS (NUM_BANKS),
        .DATA_W    (DATA_W),
        .BYTE_W    (BYTE_W),
        .ALU_LAT   (ALU_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_op        (instr_op),
        .instr_src       (instr_src),
        .instr_dst       (instr_dst),
        .src_sel         (src_sel),
        .dst_sel         (dst_sel),
        .out_sel         (out_sel),
        .bram_in_sel     (bram_in_sel),
        .bank_wr_en      (bank_wr_en),
        .bank_byte_wr_en (bank_byte_wr_en),
        .bank_clr        (bank_clr),
        .offset          (offset),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .unload_valid    (unload_valid),
        .unload_ready    (unload_ready),
        .busy            (busy),
        .done            (done),
        .err_illegal     (err_illegal)
    );

    int errors = 0;
    int checks = 0;

    // Expected values for the cycle being checked.
    logic       e_busy;
    logic [3:0] e_wr;
    logic [3:0] e_bwr;
    logic [3:0] e_clr;
    logic       e_cp;
    logic       e_lr;
    logic       e_uv;
    int         e_off;
    logic       e_done;
    logic       e_err;
    int         e_src;
    int         e_dst;
    int         e_out;

    // Pulses owed to the next cycle.
    logic nd = 1'b0;
    logic ne = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input bit full);
        checkOutput({tag, ".busy"},        32'(busy),            32'(e_busy));
        checkOutput({tag, ".instr_ready"}, 32'(instr_ready),     32'(!e_busy));
        checkOutput({tag, ".wr_en"},       32'(bank_wr_en),      32'(e_wr));
        checkOutput({tag, ".byte_wr_en"},  32'(bank_byte_wr_en), 32'(e_bwr));
        checkOutput({tag, ".clr"},         32'(bank_clr),        32'(e_clr));
        checkOutput({tag, ".bram_in_sel"}, 32'(bram_in_sel),     32'(e_cp));
        checkOutput({tag, ".load_ready"},  32'(load_ready),      32'(e_lr));
        checkOutput({tag, ".unload_vld"},  32'(unload_valid),    32'(e_uv));
        if (full) begin
            checkOutput({tag, ".offset"},  32'(offset),          32'(e_off));
            checkOutput({tag, ".done"},    32'(done),            32'(e_done));
            checkOutput({tag, ".err"},     32'(err_illegal),     32'(e_err));
            checkOutput({tag, ".src_sel"}, 32'(src_sel),         32'(e_src));
            checkOutput({tag, ".dst_sel"}, 32'(dst_sel),         32'(e_dst));
            checkOutput({tag, ".out_sel"}, 32'(out_sel),         32'(e_out));
        end
    endtask

    task automatic beginCycle(input logic is_busy);
        e_busy = is_busy;
        e_wr   = 4'b0;
        e_bwr  = 4'b0;
        e_clr  = 4'b0;
        e_cp   = 1'b0;
        e_lr   = 1'b0;
        e_uv   = 1'b0;
        e_off  = 0;
        e_done = nd;
        e_err  = ne;
        nd     = 1'b0;
        ne     = 1'b0;
    endtask

    // Inputs the DUT must ignore in the current cycle.
    task automatic driveNoise();
        instr_valid  = 1'($urandom_range(0, 1));
        instr_op     = 4'($urandom_range(0, 15));
        instr_src    = 2'($urandom_range(0, 3));
        instr_dst    = 2'($urandom_range(0, 3));
        load_valid   = 1'($urandom_range(0, 1));
        unload_ready = 1'($urandom_range(0, 1));
    endtask

    // Check the current cycle after inputs settle, then advance one clock.
    task automatic endCycle(input string tag, input bit full);
        #1;
        checkAll(tag, full);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            beginCycle(1'b1);
            driveNoise();
            reset      = 1'b1;
            load_valid = 1'b1;
            e_clr      = 4'hF;
            e_done     = 1'b0;
            e_err      = 1'b0;
            e_src      = 0;
            e_dst      = 0;
            e_out      = 0;
            endCycle("reset", i > 0);
        end
        nd = 1'b0;
        ne = 1'b0;
        beginCycle(1'b1);
        driveNoise();
        reset = 1'b0;
        e_clr = 4'hF;
        endCycle("rst_clr", 1'b1);
    endtask

    // Runs one instruction. mode 1: load_valid toggles 1,0,1...;
    // mode 2: unload_ready held low for 5 cycles at beat 32.
    // abort_at >= 0 stops a stream instruction at that beat (caller resets).
    task automatic applyStimulus(input logic [3:0] op, input int src, input int dst,
                                 input int gaps, input int mode, input int abort_at,
                                 output bit aborted);
        int beat;
        int k;
        int stalls;
        logic hs;
        aborted = 1'b0;
        for (int g = 0; g < gaps; g++) begin
            beginCycle(1'b0);
            driveNoise();
            instr_valid = 1'b0;
            endCycle("idle", 1'b1);
        end
        beginCycle(1'b0);
        driveNoise();
        instr_valid = 1'b1;
        instr_op    = op;
        instr_src   = 2'(src);
        instr_dst   = 2'(dst);
        endCycle("accept", 1'b1);
        e_src = src;
        e_dst = dst;
        case (op[3:2])
            2'b00: begin
            end
            2'b10: ne = 1'b1;
            2'b11: begin
                e_out = int'(op[1:0]);
                for (int i = 0; i < ALU_LAT; i++) begin
                    beginCycle(1'b1);
                    driveNoise();
                    endCycle("exec", 1'b1);
                end
                beginCycle(1'b1);
                driveNoise();
                e_wr = 4'b0001 << dst;
                endCycle("alu_write", 1'b1);
                nd = 1'b1;
            end
            default: begin
                if (op[1:0] == 2'b01 || op[1:0] == 2'b11) begin
                    beginCycle(1'b1);
                    driveNoise();
                    if (op[1:0] == 2'b01) begin
                        e_wr = 4'b0001 << dst;
                        e_cp = 1'b1;
                    end else begin
                        e_clr = 4'b0001 << dst;
                    end
                    endCycle(op[1:0] == 2'b01 ? "copy" : "clear", 1'b1);
                    nd = 1'b1;
                end else begin
                    beat   = 0;
                    k      = 0;
                    stalls = 0;
                    while (beat < BEATS && !aborted) begin
                        if (beat == abort_at) begin
                            aborted = 1'b1;
                        end else begin
                            beginCycle(1'b1);
                            driveNoise();
                            if (mode == 1)
                                hs = (k % 2 == 0);
                            else if (mode == 2 && beat == 32 && stalls < 5) begin
                                hs = 1'b0;
                                stalls++;
                            end else if (mode == 2)
                                hs = 1'b1;
                            else
                                hs = 1'($urandom_range(0, 1));
                            e_off = beat * BYTE_W;
                            if (op[1:0] == 2'b00) begin
                                load_valid = hs;
                                e_lr  = 1'b1;
                                e_bwr = hs ? (4'b0001 << dst) : 4'b0;
                                endCycle("load", 1'b1);
                            end else begin
                                unload_ready = hs;
                                e_uv = 1'b1;
                                endCycle("unload", 1'b1);
                            end
                            if (hs) beat++;
                            k++;
                        end
                    end
                    if (!aborted) nd = 1'b1;
                end
            end
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ab;
        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr_op     = 4'h0;
        instr_src    = '0;
        instr_dst    = '0;
        load_valid   = 1'b0;
        unload_ready = 1'b0;

        $display("[TB] reset sequence");
        doReset(2);

        $display("[TB] ADD with ALU latency");
        applyStimulus(4'hC, 1, 2, 1, 0, -1, ab);

        $display("[TB] LOAD with toggling valid");
        applyStimulus(4'h4, 0, 3, 0, 1, -1, ab);

        $display("[TB] UNLOAD with mid-stream stall");
        applyStimulus(4'h6, 0, 1, 0, 2, -1, ab);

        $display("[TB] illegal, NOP, CLEAR back-to-back");
        applyStimulus(4'hA, 2, 3, 0, 0, -1, ab);
        applyStimulus(4'h0, 1, 2, 0, 0, -1, ab);
        applyStimulus(4'h7, 3, 1, 0, 0, -1, ab);

        $display("[TB] reset during LOAD");
        applyStimulus(4'h4, 2, 2, 0, 0, 20, ab);
        checkOutput("abort_reached", 32'(ab), 32'(1));
        doReset(2);
        applyStimulus(4'h4, 1, 0, 0, 0, -1, ab);

        $display("[TB] random instruction stream");
        repeat (120) begin
            applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                          0, -1, ab);
        end

        beginCycle(1'b0);
        driveNoise();
        instr_valid = 1'b0;
        endCycle("tail", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_ctrl_fsm.md
Name: mpu_ctrl_fsm

Overview:
- Parametrised instruction sequencer for the matrix processing unit.
- Accepts one instruction per valid/ready handshake and steers the bank read/write muxes, the function-unit output mux and per-bank write/byte-write/clear strobes.
- Generalises bank count, vector width, byte width and function-unit latency.
- Adds flow-controlled LOAD/UNLOAD byte streams, a completion pulse and an illegal-opcode flag.

Parameters:
- NUM_BANKS, 4, number of BRAM banks; power of two, >=2. SEL_W = clog2(NUM_BANKS).
- DATA_W, 512, bank word width in bits.
- BYTE_W, 8, host stream beat width. DATA_W % BYTE_W == 0. BEATS = DATA_W/BYTE_W; OFF_W = clog2(DATA_W).
- ALU_LAT, 0, extra cycles the function units need before the result is valid (0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  FSM can accept (== !busy).
- instr_op  in  4  opcode.
- instr_src  in  SEL_W  source bank (A operand / unload bank).
- instr_dst  in  SEL_W  destination bank (D operand).
- src_sel  out  SEL_W  registered read-mux select.
- dst_sel  out  SEL_W  registered write-mux select.
- out_sel  out  2  function-unit mux: 0 add, 1 shift, 2 sub, 3 mult.
- bram_in_sel  out  1  1 = bank-to-bank copy path.
- bank_wr_en  out  NUM_BANKS  full-word write strobes.
- bank_byte_wr_en  out  NUM_BANKS  single-beat write strobes.
- bank_clr  out  NUM_BANKS  bank clear strobes.
- offset  out  OFF_W  bit offset of the current beat.
- load_valid  in  1  host beat present.
- load_ready  out  1  FSM consumes a beat.
- unload_valid  out  1  read beat presented to host.
- unload_ready  in  1  host takes the beat.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.
- err_illegal  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Opcodes:
  - 00xx NOP.
  - 0100 LOAD, 0101 COPY, 0110 UNLOAD, 0111 CLEAR.
  - 1100 ADD, 1101 SHIFT, 1110 SUB, 1111 MULT.
  - 10xx illegal.
- States: RST_CLR, IDLE, EXEC, WRITE, LOAD, UNLOAD, CLEAR.
- Reset:
  - At the first edge with reset high, state becomes RST_CLR. Counters, offset, src_sel, dst_sel and out_sel go to 0; done and err_illegal go to 0.
  - The cycle after reset deasserts (and every cycle reset stays high), bank_clr is all ones and busy=1.
  - The next state is IDLE.
  - Reset mid-operation aborts immediately. No further strobes for the aborted instruction; all banks are cleared.
- Defaults every cycle:
  - All strobes 0; bram_in_sel 0; load_ready 0; unload_valid 0.
  - busy = (state != IDLE).
- IDLE:
  - instr_ready=1; offset=0.
  - Accept happens on an edge where instr_valid & instr_ready. At accept, latch src_sel and dst_sel. For ALU ops, also latch out_sel.
  - Next state:
    - NOP -> IDLE, no done.
    - Illegal -> IDLE, err_illegal=1 next cycle, no done.
    - ALU -> EXEC if ALU_LAT>0, else WRITE.
    - COPY -> WRITE with bram_in_sel.
    - CLEAR -> CLEAR.
    - LOAD -> LOAD.
    - UNLOAD -> UNLOAD.
  - instr_valid while busy is ignored; the requester holds it until ready.
- EXEC: stay exactly ALU_LAT cycles (down-counter), then WRITE.
- WRITE: one cycle with bank_wr_en[dst_sel]=1. For COPY, bram_in_sel=1. Then IDLE.
- CLEAR: one cycle with bank_clr[dst_sel]=1, then IDLE.
- LOAD:
  - load_ready=1.
  - bank_byte_wr_en[dst_sel] = load_valid (combinational).
  - offset = beat*BYTE_W.
  - beat increments only on load_valid.
  - After the transfer with beat==BEATS-1 -> IDLE.
  - Stalls (load_valid=0) hold beat and offset indefinitely.
- UNLOAD:
  - unload_valid=1; offset = beat*BYTE_W; read bank = src_sel.
  - beat increments on unload_ready.
  - After the beat==BEATS-1 transfer -> IDLE.
- done=1 for exactly the first IDLE cycle after a WRITE, CLEAR, LOAD or UNLOAD completes.
  - A back-to-back accept is legal in that same cycle.
- ALU latency from accept edge to wr_en cycle is ALU_LAT+1 cycles.
- The beat counter never wraps inside an instruction. It is cleared on entering IDLE.

Test Plan:
1. Reset 2 cycles -> bank_clr=4'b1111 for 3 cycles total (2 during reset, 1 after), busy=1; then IDLE with instr_ready=1 and all other outputs 0.
2. ALU_LAT=3, ADD src=1 dst=2 -> out_sel=0, src_sel=1; bank_wr_en=4'b0100 exactly 4 cycles after accept, for 1 cycle; done pulses the next cycle.
3. LOAD dst=3 with load_valid toggling 1,0,1,... -> bank_byte_wr_en=4'b1000 only on valid cycles; offset 0,8,...,504; 64 transfers, then done; busy high throughout.
4. UNLOAD src=0, unload_ready low for 5 cycles mid-stream -> offset and unload_valid held; exactly 64 beats; returns to IDLE.
5. Opcode 1010, then NOP, then CLEAR dst=1 back-to-back -> err_illegal 1 cycle; no done for the NOP; bank_clr=4'b0010 one cycle, then done.
6. Reset asserted at beat 20 of a LOAD -> byte_wr_en drops; RST_CLR clears all banks; a subsequent LOAD restarts at offset 0.
